multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control FSM for the team's multicycle MIPS datapath: one shared memory for instructions and data, one shared ALU, plus IR, PC, A/B/ALUOut registers.
- Decodes op/Funct held in IR and sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath mux selects, write enables and ALUControl.
- Stalls on a memory ready handshake.

Parameters:
- RESET_STATE, 4'd0, FSM state entered on reset (FETCH encoding).

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  synchronous reset, active-low.
- op  input  6  IR[31:26].
- Funct  input  6  IR[5:0].
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access completes this cycle.
- mem_req  output  1  memory access request.
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  load IR.
- RegDst  output  1  0 = rt, 1 = rd.
- MemtoReg  output  1  0 = ALUOut, 1 = MDR.
- RegWrite  output  1  register file write.
- AluSrcA  output  1  0 = PC, 1 = A.
- AluSrcB  output  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- PCWrite  output  1  effective PC load enable (unconditional or branch-taken).
- ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode or funct.

Behaviour:
- State register only; all outputs are combinational from state, op, Funct, Zero, mem_ready.
- Reset: resetn sampled low at a clk edge puts state at FETCH. While resetn is low, every enable and strobe is forced 0: MemWrite, IRWrite, RegWrite, PCWrite, mem_req, illegal_op.
- Reset mid-instruction: the instruction is abandoned with no partial write after the reset edge.
- Unlisted outputs are 0 in each state.
- States and transitions:
  - FETCH: mem_req=1, IorD=0, AluSrcA=0, AluSrcB=01, ALUControl=add, PCSrc=00. IRWrite and PCWrite equal mem_ready. Go to DECODE when mem_ready, else hold.
  - DECODE: AluSrcA=0, AluSrcB=11, add (branch target into ALUOut). Next state by op:
    - lw 100011 or sw 101011 -> MEMADR
    - R-type 000000 -> EXEC
    - beq 000100 -> BRANCH
    - addi 001000 -> ADDIEX
    - j 000010 -> JUMP
    - otherwise illegal_op=1 and go to FETCH
  - MEMADR: AluSrcA=1, AluSrcB=10, add. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: mem_req=1, IorD=1. Go to MEMWB when mem_ready, else hold.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
  - MEMWR: mem_req=1, IorD=1, MemWrite=mem_ready. Go to FETCH when mem_ready, else hold.
  - EXEC: AluSrcA=1, AluSrcB=00, ALUControl from Funct:
    - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
    - Other Funct: illegal_op=1, go to FETCH, no writeback.
    - Legal Funct: go to ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Go to FETCH.
  - BRANCH: AluSrcA=1, AluSrcB=00, sub, PCSrc=01, PCWrite=Zero. Go to FETCH.
  - ADDIEX: AluSrcA=1, AluSrcB=10, add. Go to ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH.
  - JUMP: PCSrc=10, PCWrite=1. Go to FETCH.
- Cycle counts, excluding wait cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each mem_ready-low cycle in FETCH, MEMRD or MEMWR adds one cycle. No write strobe fires during a wait cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Unreachable state encodings go to FETCH on the next edge with all enables 0.

Optional Feature:
- Macro MULTICYCLE_BNE_EN.
- Defined: op 000101 (bne) in DECODE goes to BRANCH. In BRANCH, PCWrite = ~Zero for bne and Zero for beq.
- Not defined: 000101 is illegal; illegal_op pulses and the FSM returns to FETCH.

Test Plan:
- resetn=0 for 2 cycles mid-EXEC, then release -> all enables 0 during reset; first state after release is FETCH with mem_req=1, IorD=0.
- lw (op 100011), mem_ready held 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 with MemtoReg=1 and RegDst=0 only in cycle 5.
- sw with mem_ready=0 for 3 cycles in MEMWR -> MemWrite=0 for those 3 cycles, MemWrite=1 for exactly 1 cycle, then FETCH; total 7 cycles.
- R-type Funct 101010 -> ALUControl=111 in EXEC; RegWrite=1 with RegDst=1 in ALUWB. Funct 000111 -> illegal_op pulse and no RegWrite.
- beq with Zero=1 -> PCWrite=1 and PCSrc=01 in cycle 3; with Zero=0 -> PCWrite=0. j -> PCSrc=10 and PCWrite=1 in cycle 3.
- op 000101, macro defined with Zero=0 -> PCWrite=1 in BRANCH. Macro undefined -> illegal_op=1 in DECODE, then FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The controller takes the master modport and the datapath takes the slave modport.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [1:0] PCSrc;
  logic       PCWrite;
  logic [2:0] ALUControl;
  logic       illegal_op;

  modport master (
    input  op, Funct, Zero, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           AluSrcA, AluSrcB, PCSrc, PCWrite, ALUControl, illegal_op
  );

  modport slave (
    output op, Funct, Zero, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           AluSrcA, AluSrcB, PCSrc, PCWrite, ALUControl, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Defining MULTICYCLE_BNE_EN adds bne (op 000101) through the BRANCH state.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                   clk,
  input  logic                   resetn,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Returns {legal, ALUControl} for an R-type Funct field.
  function automatic logic [3:0] decode_funct(input logic [5:0] funct);
    case (funct)
      6'b100000: decode_funct = {1'b1, ALU_ADD};
      6'b100010: decode_funct = {1'b1, ALU_SUB};
      6'b100100: decode_funct = {1'b1, ALU_AND};
      6'b100101: decode_funct = {1'b1, ALU_OR};
      6'b101010: decode_funct = {1'b1, ALU_SLT};
      default:   decode_funct = 4'b0000;
    endcase
  endfunction

  state_t     state, state_next;
  logic [3:0] funct_dec;
  logic       mem_req_raw, mem_write_raw, ir_write_raw, reg_write_raw;
  logic       pc_write_raw, illegal_raw;
  logic       iord, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;

  assign funct_dec = decode_funct(bus.Funct);

  always_ff @(posedge clk) begin
    if (!resetn) state <= state_t'(RESET_STATE);
    else         state <= state_next;
  end

  always_comb begin
    state_next    = FETCH;
    mem_req_raw   = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    pc_write_raw  = 1'b0;
    illegal_raw   = 1'b0;
    iord          = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_ctrl      = 3'b000;
    case (state)
      FETCH: begin
        mem_req_raw  = 1'b1;
        alu_src_b    = 2'b01;
        alu_ctrl     = ALU_ADD;
        ir_write_raw = bus.mem_ready;
        pc_write_raw = bus.mem_ready;
        state_next   = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        case (bus.op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXEC;
          OP_BEQ:       state_next = BRANCH;
`ifdef MULTICYCLE_BNE_EN
          OP_BNE:       state_next = BRANCH;
`endif
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default: begin
            illegal_raw = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        if (bus.op == OP_SW)      state_next = MEMWR;
        else if (bus.op == OP_LW) state_next = MEMRD;
        else                      state_next = FETCH;
      end
      MEMRD: begin
        mem_req_raw = 1'b1;
        iord        = 1'b1;
        state_next  = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
      end
      MEMWR: begin
        mem_req_raw   = 1'b1;
        iord          = 1'b1;
        mem_write_raw = bus.mem_ready;
        state_next    = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        if (funct_dec[3]) begin
          alu_ctrl   = funct_dec[2:0];
          state_next = ALUWB;
        end else begin
          illegal_raw = 1'b1;
          state_next  = FETCH;
        end
      end
      ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
`ifdef MULTICYCLE_BNE_EN
        pc_write_raw = (bus.op == OP_BNE) ? ~bus.Zero : bus.Zero;
`else
        pc_write_raw = bus.Zero;
`endif
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_ctrl   = ALU_ADD;
        state_next = ADDIWB;
      end
      ADDIWB: reg_write_raw = 1'b1;
      JUMP: begin
        pc_src       = 2'b10;
        pc_write_raw = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Strobes are masked while reset is held so an abandoned instruction writes nothing.
  assign bus.mem_req    = resetn & mem_req_raw;
  assign bus.MemWrite   = resetn & mem_write_raw;
  assign bus.IRWrite    = resetn & ir_write_raw;
  assign bus.RegWrite   = resetn & reg_write_raw;
  assign bus.PCWrite    = resetn & pc_write_raw;
  assign bus.illegal_op = resetn & illegal_raw;
  assign bus.IorD       = iord;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.AluSrcA    = alu_src_a;
  assign bus.AluSrcB    = alu_src_b;
  assign bus.PCSrc      = pc_src;
  assign bus.ALUControl = alu_ctrl;

endmodule
